// File: rtl/mem_port_arbiter_if.sv
// Requester-side and memory-side signals of the shared read port.
// The arbiter connects through the slave modport.
interface mem_port_arbiter_if #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]            req_valid_i;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i;
    logic [NUM_REQ-1:0]            req_ready_o;
    logic [NUM_REQ-1:0]            rsp_valid_o;
    logic [DATA_WIDTH-1:0]         rsp_data_o;
    logic                          mem_valid_o;
    logic [ADDR_WIDTH-1:0]         mem_addr_o;
    logic                          mem_valid_i;
    logic [DATA_WIDTH-1:0]         mem_data_i;
    logic                          err_o;

    modport master (
        output req_valid_i, req_addr_i, mem_valid_i, mem_data_i,
        input  req_ready_o, rsp_valid_o, rsp_data_o, mem_valid_o, mem_addr_o, err_o
    );

    modport slave (
        input  req_valid_i, req_addr_i, mem_valid_i, mem_data_i,
        output req_ready_o, rsp_valid_o, rsp_data_o, mem_valid_o, mem_addr_o, err_o
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one in-order fixed-latency read port among NUM_REQ
// requesters; a tag FIFO routes each returned word to the requester that issued it.
module mem_port_arbiter #(
    parameter int NUM_REQ         = 2,
    parameter int ADDR_WIDTH      = 8,
    parameter int DATA_WIDTH      = 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input logic              clk,
    input logic              rst_n,
    mem_port_arbiter_if.slave bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0]   CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0]   PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [NUM_REQ-1:0] REQ_ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] oh;
        oh = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            oh[i] = (idx == IDX_W'(i));
        end
        return oh;
    endfunction

    logic [IDX_W-1:0]      last_grant_r;
    logic [IDX_W-1:0]      tag_mem_r [MAX_OUTSTANDING];
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [CNT_W-1:0]      count_r;
    logic                  mem_valid_r;
    logic [ADDR_WIDTH-1:0] mem_addr_r;
    logic [NUM_REQ-1:0]    rsp_valid_r;
    logic [DATA_WIDTH-1:0] rsp_data_r;
    logic                  err_r;

    logic                  can_grant_s;
    logic [NUM_REQ-1:0]    hi_s;
    logic [NUM_REQ-1:0]    lo_s;
    logic [NUM_REQ-1:0]    pick_s;
    logic [NUM_REQ-1:0]    grant_s;
    logic [IDX_W-1:0]      grant_idx_s;
    logic [ADDR_WIDTH-1:0] sel_addr_s;
    logic                  accept_s;
    logic                  fifo_empty_s;
    logic                  pop_s;
    logic                  spurious_s;
    logic [CNT_W-1:0]      count_nxt_s;

    // Ready is forced low while reset is asserted, not just after the first edge.
    assign can_grant_s  = rst_n && (count_r < CNT_MAX);
    assign accept_s     = |grant_s;
    assign fifo_empty_s = (count_r == {CNT_W{1'b0}});
    assign pop_s        = bus.mem_valid_i && !fifo_empty_s;
    assign spurious_s   = bus.mem_valid_i && fifo_empty_s;

    // Rotating priority: indices above last_grant first, otherwise wrap to the lowest valid.
    always_comb begin
        hi_s        = '0;
        lo_s        = '0;
        grant_idx_s = '0;
        sel_addr_s  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            hi_s[i] = bus.req_valid_i[i] && (IDX_W'(i) > last_grant_r);
            lo_s[i] = bus.req_valid_i[i] && (IDX_W'(i) <= last_grant_r);
        end
        pick_s  = (|hi_s) ? hi_s : lo_s;
        grant_s = can_grant_s ? (pick_s & (~pick_s + REQ_ONE)) : {NUM_REQ{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_idx_s = grant_idx_s | (grant_s[i] ? IDX_W'(i) : {IDX_W{1'b0}});
            sel_addr_s  = sel_addr_s |
                          (bus.req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH] & {ADDR_WIDTH{grant_s[i]}});
        end
    end

    // Outstanding count: simultaneous push and pop leave it unchanged.
    always_comb begin
        case ({accept_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Issue/response registers, tag FIFO and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_r <= IDX_W'(NUM_REQ - 1);
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                tag_mem_r[i] <= '0;
            end
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= '0;
            mem_valid_r <= 1'b0;
            mem_addr_r  <= '0;
            rsp_valid_r <= '0;
            rsp_data_r  <= '0;
            err_r       <= 1'b0;
        end else begin
            count_r     <= count_nxt_s;
            mem_valid_r <= accept_s;
            rsp_valid_r <= pop_s ? idx_to_onehot(tag_mem_r[rd_ptr_r]) : {NUM_REQ{1'b0}};
            if (accept_s) begin
                last_grant_r        <= grant_idx_s;
                tag_mem_r[wr_ptr_r] <= grant_idx_s;
                wr_ptr_r            <= wr_ptr_r + PTR_ONE;
                mem_addr_r          <= sel_addr_s;
            end
            if (pop_s) begin
                rd_ptr_r   <= rd_ptr_r + PTR_ONE;
                rsp_data_r <= bus.mem_data_i;
            end
            if (spurious_s) begin
                err_r <= 1'b1;
            end
        end
    end

    assign bus.req_ready_o = grant_s;
    assign bus.rsp_valid_o = rsp_valid_r;
    assign bus.rsp_data_o  = rsp_data_r;
    assign bus.mem_valid_o = mem_valid_r;
    assign bus.mem_addr_o  = mem_addr_r;
    assign bus.err_o       = err_r;
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Round-robin arbiter that shares one read-only, in-order, fixed-latency memory port (valid/addr in, valid/data out) between NUM_REQ requesters, e.g. instruction fetch and data load in the W0RM core. It issues at most one memory read per cycle and records the issuing requester in a tag FIFO. Each returned word is routed back to that requester. A sticky error flag catches responses that arrive with no request outstanding.

## Interface
Parameters:
- NUM_REQ, 2: number of requesters (2..8).
- ADDR_WIDTH, 8: address width, passed through unchanged.
- DATA_WIDTH, 8: data width.
- MAX_OUTSTANDING, 4: tag FIFO depth (power of two, ≥2). It must exceed the memory round-trip latency in cycles for full throughput.

Ports:
- clk  in  1  single clock, rising edge. One clock; reset is asynchronous and active-low.
- rst_n  in  1  asynchronous active-low reset.
- req_valid_i  in  NUM_REQ  per-requester read request.
- req_addr_i  in  NUM_REQ*ADDR_WIDTH  per-requester address; requester i uses slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_ready_o  out  NUM_REQ  one-hot grant; a request is accepted when valid and ready are both high.
- rsp_valid_o  out  NUM_REQ  one-hot, one-cycle response strobe.
- rsp_data_o  out  DATA_WIDTH  response data, broadcast to all requesters and qualified by rsp_valid_o.
- mem_valid_o  out  1  read strobe to the memory.
- mem_addr_o  out  ADDR_WIDTH  read address to the memory.
- mem_valid_i  in  1  memory response strobe.
- mem_data_i  in  DATA_WIDTH  memory response data.
- err_o  out  1  sticky flag: a response arrived while the tag FIFO was empty.

## Operation
Arbitration:
- Grant rule: a grant is possible only when outstanding count < MAX_OUTSTANDING.
- Search order starts at (last_grant+1) mod NUM_REQ and wraps. The first requester with req_valid_i set receives req_ready_o; all other ready bits stay 0.
- req_ready_o is combinational from req_valid_i, last_grant and the count.
- Requesters hold valid and addr stable until accepted. A requester may drop valid before acceptance without penalty.
- On acceptance:
  - last_grant is set to the winning index.
  - The winner's index is pushed into the tag FIFO.
  - mem_valid_o/mem_addr_o are registered with the winner's address.
  - count increments.
- If no request is accepted in a cycle, mem_valid_o is 0 in the next cycle and mem_addr_o holds its last value.

Response:
- When mem_valid_i is high and the FIFO is non-empty, the arbiter pops the head tag t.
- Next cycle: rsp_valid_o[t] is 1, rsp_data_o is the captured mem_data_i, and count decrements.
- When mem_valid_i is high and the FIFO is empty: err_o is set, nothing is popped, and rsp_valid_o stays 0. err_o is cleared only by reset.

Boundary conditions:
- Accept and response in the same cycle: push and pop both happen and count is unchanged.
- FIFO full: all req_ready_o are 0. A pop in the same cycle does not reopen the grant until the next cycle (no bypass).
- Pointer and count wrap-around: FIFO pointers are log2(MAX_OUTSTANDING) bits and wrap naturally. count is one bit wider.
- Single active requester: it is granted every cycle while count allows.

## Timing
- Reset values: req_ready_o = 0 while rst_n is low. last_grant = NUM_REQ-1, so requester 0 wins first after reset.
- All of the following reset to 0: mem_valid_o, mem_addr_o, rsp_valid_o, rsp_data_o, err_o, count, FIFO pointers.
- Reset mid-operation: all in-flight tags are discarded. A memory response arriving after reset sets err_o. The system resets the memory together with the arbiter.
- Issue latency: accepted at edge T, so mem_valid_o is high during cycle T+1.
- Response latency: mem_valid_i at edge R, so rsp_valid_o is high during cycle R+1.
- Total latency with a 1-cycle memory: accept at T, response at T+3.
- Throughput: one request per cycle sustained when MAX_OUTSTANDING > memory round trip (3 for a 1-cycle memory).

## Test plan
- Reset then idle:
  - Stimulus: assert rst_n low mid-cycle; keep req_valid_i = 0 after release.
  - Required: all outputs 0 asynchronously during reset; mem_valid_o stays 0 afterwards.
- Single read, NUM_REQ=2, 1-cycle memory:
  - Stimulus: requester 1 requests addr 0x10, memory returns 0xA5.
  - Required: req_ready_o = 2'b10 at T; mem_addr_o = 0x10 at T+1; rsp_valid_o = 2'b10 with rsp_data_o = 0xA5 at T+3.
- Round-robin:
  - Stimulus: both requesters hold valid continuously.
  - Required: grants alternate 0,1,0,1 starting with 0; responses return in the same order carrying each requester's own data.
- Backpressure, MAX_OUTSTANDING=2, 3-cycle memory:
  - Stimulus: continuous requests.
  - Required: at most 2 outstanding; req_ready_o = 0 while full; grant resumes the cycle after the first pop.
- Spurious response:
  - Stimulus: mem_valid_i = 1 with the FIFO empty.
  - Required: err_o becomes 1 and stays 1 until reset; no rsp_valid_o bit asserts.
- Simultaneous accept and pop:
  - Stimulus: acceptance and mem_valid_i in the same cycle.
  - Required: count unchanged; both the tag order and the data are correct.
